// File: rtl/grid_input_buffer.sv
// ---------------------------------------------------------------------------
// grid_input_buffer
//   Host-to-grid packet FIFO with batch commit. The host writes packets at
//   any rate, but the grid sees none of them until the host pulses commit.
//   Commit publishes every packet written so far. The read side is
//   first-word-fall-through and feeds the west-edge router of core 0.
//
// Ports
//   clk              single clock, rising edge
//   rst              synchronous active-low reset
//   tick             global tick pulse, shared with the core grid
//   wr_en / wr_data  host write request and packet
//   wr_ready         FIFO not full
//   commit           publish all packets written so far
//   ren              pop request from the grid
//   packet_out       head-of-queue packet, valid whenever empty = 0
//   empty            no committed packet is available to the grid
//   occupancy        stored entries, committed plus uncommitted
//   overflow_error   sticky: a write arrived while the FIFO was full
//   underflow_error  sticky: a pop arrived while empty
//   batch_late_error sticky: a tick arrived before the batch had drained
//
// Optional feature (macro GRID_INPUT_BUFFER_STATS_EN)
//   pop_count        32-bit count of accepted pops, wraps on overflow
//   commit_count     16-bit count of commit pulses, wraps on overflow
// ---------------------------------------------------------------------------
module grid_input_buffer #(
   parameter int unsigned PACKET_WIDTH = 30,
   parameter int unsigned DEPTH        = 512
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       tick,
   input  logic                       wr_en,
   input  logic [PACKET_WIDTH-1:0]    wr_data,
   output logic                       wr_ready,
   input  logic                       commit,
   input  logic                       ren,
   output logic [PACKET_WIDTH-1:0]    packet_out,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     occupancy,
`ifdef GRID_INPUT_BUFFER_STATS_EN
   output logic [31:0]                pop_count,
   output logic [15:0]                commit_count,
`endif
   output logic                       overflow_error,
   output logic                       underflow_error,
   output logic                       batch_late_error
);

   localparam int unsigned AW = $clog2(DEPTH);   // storage address width
   localparam int unsigned PW = AW + 1;          // pointer width, extra MSB is the wrap bit

   logic [PACKET_WIDTH-1:0] mem [DEPTH];

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] commit_ptr;
   logic [PW-1:0] rd_ptr;

   logic          full;
   logic          wr_accept;
   logic          wr_drop;
   logic          rd_accept;
   logic          rd_drop;
   logic          tick_late;
   logic [PW-1:0] wr_ptr_nxt;
   logic [PW-1:0] commit_ptr_nxt;
   logic [PW-1:0] rd_ptr_nxt;

   // Full when the pointers name the same slot but sit on opposite laps.
   always_comb begin
      full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   end

   assign wr_ready   = !full;
   assign empty      = (rd_ptr == commit_ptr);
   assign occupancy  = wr_ptr - rd_ptr;
   assign packet_out = mem[rd_ptr[AW-1:0]];

   // Per-cycle events, all judged on the state at the start of the cycle.
   // A pop while full frees its slot only from the next cycle on.
   always_comb begin
      wr_accept = wr_en && !full;
      wr_drop   = wr_en && full;
      rd_accept = ren && !empty;
      rd_drop   = ren && empty;
      tick_late = tick && !empty;
   end

   // Next pointer values. Commit takes the post-write pointer, so a write
   // accepted in the same cycle is part of the published batch.
   always_comb begin
      wr_ptr_nxt     = wr_ptr;
      rd_ptr_nxt     = rd_ptr;
      commit_ptr_nxt = commit_ptr;
      if (wr_accept) begin
         wr_ptr_nxt = wr_ptr + PW'(1);
      end
      if (rd_accept) begin
         rd_ptr_nxt = rd_ptr + PW'(1);
      end
      if (commit) begin
         commit_ptr_nxt = wr_ptr_nxt;
      end
   end

   // Pointer and sticky-flag state.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr           <= '0;
         commit_ptr       <= '0;
         rd_ptr           <= '0;
         overflow_error   <= 1'b0;
         underflow_error  <= 1'b0;
         batch_late_error <= 1'b0;
      end else begin
         wr_ptr     <= wr_ptr_nxt;
         commit_ptr <= commit_ptr_nxt;
         rd_ptr     <= rd_ptr_nxt;
         if (wr_drop) begin
            overflow_error <= 1'b1;
         end
         if (rd_drop) begin
            underflow_error <= 1'b1;
         end
         if (tick_late) begin
            batch_late_error <= 1'b1;
         end
      end
   end

   // Packet storage. It is not cleared by reset, and writes are blocked
   // while reset is held.
   always_ff @(posedge clk) begin
      if (rst && wr_accept) begin
         mem[wr_ptr[AW-1:0]] <= wr_data;
      end
   end

`ifdef GRID_INPUT_BUFFER_STATS_EN
   // Free-running activity counters that wrap on overflow.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pop_count    <= '0;
         commit_count <= '0;
      end else begin
         if (rd_accept) begin
            pop_count <= pop_count + 32'(1);
         end
         if (commit) begin
            commit_count <= commit_count + 16'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_grid_input_buffer.sv
// ---------------------------------------------------------------------------
// tb_grid_input_buffer
//   Directed bench for grid_input_buffer. Instance dut16 (DEPTH=16) covers
//   commit visibility, underflow, tick lateness and reset. Instance dut4
//   (DEPTH=4) covers the full and overflow boundary. The select signal sel
//   routes the shared stimulus to one instance at a time.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_grid_input_buffer;

   localparam int unsigned PKW = 30;

   logic           clk = 1'b0;
   logic           rst;
   logic           sel;
   logic           tick, wr_en, commit, ren;
   logic [PKW-1:0] wr_data;

   logic           a_tick, a_wr_en, a_commit, a_ren;
   logic           b_tick, b_wr_en, b_commit, b_ren;

   logic           a_wr_ready, a_empty, a_ovf, a_udf, a_late;
   logic [PKW-1:0] a_pkt;
   logic [4:0]     a_occ;
   logic           b_wr_ready, b_empty, b_ovf, b_udf, b_late;
   logic [PKW-1:0] b_pkt;
   logic [2:0]     b_occ;
`ifdef GRID_INPUT_BUFFER_STATS_EN
   logic [31:0]    a_pops, b_pops;
   logic [15:0]    a_commits, b_commits;
`endif

   int n_cmp = 0;
   int n_err = 0;

   assign a_tick   = tick   & ~sel;
   assign a_wr_en  = wr_en  & ~sel;
   assign a_commit = commit & ~sel;
   assign a_ren    = ren    & ~sel;
   assign b_tick   = tick   & sel;
   assign b_wr_en  = wr_en  & sel;
   assign b_commit = commit & sel;
   assign b_ren    = ren    & sel;

   always #5 clk = ~clk;

   grid_input_buffer #(.PACKET_WIDTH(PKW), .DEPTH(16)) dut16 (
      .clk(clk), .rst(rst), .tick(a_tick), .wr_en(a_wr_en), .wr_data(wr_data),
      .wr_ready(a_wr_ready), .commit(a_commit), .ren(a_ren), .packet_out(a_pkt),
      .empty(a_empty), .occupancy(a_occ),
`ifdef GRID_INPUT_BUFFER_STATS_EN
      .pop_count(a_pops), .commit_count(a_commits),
`endif
      .overflow_error(a_ovf), .underflow_error(a_udf), .batch_late_error(a_late)
   );

   grid_input_buffer #(.PACKET_WIDTH(PKW), .DEPTH(4)) dut4 (
      .clk(clk), .rst(rst), .tick(b_tick), .wr_en(b_wr_en), .wr_data(wr_data),
      .wr_ready(b_wr_ready), .commit(b_commit), .ren(b_ren), .packet_out(b_pkt),
      .empty(b_empty), .occupancy(b_occ),
`ifdef GRID_INPUT_BUFFER_STATS_EN
      .pop_count(b_pops), .commit_count(b_commits),
`endif
      .overflow_error(b_ovf), .underflow_error(b_udf), .batch_late_error(b_late)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Inputs are applied after an edge and sampled at the next edge.
   // Outputs are checked 1 ns after that edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [PKW-1:0] d, input logic c);
      wr_en = 1'b1; wr_data = d; commit = c;
      step();
      wr_en = 1'b0; commit = 1'b0;
   endtask

   task automatic pop();
      ren = 1'b1;
      step();
      ren = 1'b0;
   endtask

   task automatic pulse_commit();
      commit = 1'b1;
      step();
      commit = 1'b0;
   endtask

   task automatic pulse_tick();
      tick = 1'b1;
      step();
      tick = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; sel = 1'b0; tick = 1'b0; wr_en = 1'b0; commit = 1'b0; ren = 1'b0;
      wr_data = '0;
      step(); step();
      rst = 1'b1;

      // Reset state of both instances.
      check("rst_empty",    32'(a_empty),    32'h1);
      check("rst_wr_ready", 32'(a_wr_ready), 32'h1);
      check("rst_occ",      32'(a_occ),      32'h0);
      check("rst_flags",    32'({a_ovf, a_udf, a_late}), 32'h0);
      check("rst4_occ",     32'(b_occ),      32'h0);

      // Written packets stay hidden from the grid until commit.
      push(30'h1, 1'b0); push(30'h2, 1'b0); push(30'h3, 1'b0);
      check("nocommit_empty", 32'(a_empty), 32'h1);
      check("nocommit_occ",   32'(a_occ),   32'h3);
      pulse_commit();
      check("commit_empty", 32'(a_empty), 32'h0);
      check("commit_head",  32'(a_pkt),   32'h1);
      pop(); check("pop_head2", 32'(a_pkt), 32'h2);
      pop(); check("pop_head3", 32'(a_pkt), 32'h3);
      pop();
      check("drain_empty", 32'(a_empty), 32'h1);
      check("drain_occ",   32'(a_occ),   32'h0);

      // A write and a commit in the same cycle: the packet is visible next cycle.
      push(30'hAB, 1'b1);
      check("wc_empty", 32'(a_empty), 32'h0);
      check("wc_head",  32'(a_pkt),   32'hAB);
      check("wc_occ",   32'(a_occ),   32'h1);
      pop();
      check("wc_drain", 32'(a_empty), 32'h1);

      // A pop while empty sets underflow and leaves the pointers unchanged.
      pop();
      check("udf_flag",  32'(a_udf),   32'h1);
      check("udf_occ",   32'(a_occ),   32'h0);
      check("udf_empty", 32'(a_empty), 32'h1);
      push(30'h55, 1'b1);
      check("udf_head", 32'(a_pkt),   32'h55);
      check("udf_vis",  32'(a_empty), 32'h0);
      pop();
      check("udf_drain", 32'(a_empty), 32'h1);
      check("udf_occ2",  32'(a_occ),   32'h0);

      // A tick that arrives before the batch has drained sets a sticky flag.
      push(30'h11, 1'b0); push(30'h12, 1'b1);
      pop();
      check("late_pre",  32'(a_late), 32'h0);
      check("late_head", 32'(a_pkt),  32'h12);
      pulse_tick();
      check("late_flag", 32'(a_late), 32'h1);
      check("late_occ",  32'(a_occ),  32'h1);
      check("late_keep", 32'(a_pkt),  32'h12);
      pop();
      check("late_empty", 32'(a_empty), 32'h1);
      pulse_tick();
      check("late_sticky", 32'(a_late), 32'h1);
      check("late_occ0",   32'(a_occ),  32'h0);

      // Mid-stream reset with operations in flight.
      rst = 1'b0; step(); rst = 1'b1;
      check("rst2_flags", 32'({a_ovf, a_udf, a_late}), 32'h0);
      for (int i = 0; i < 10; i++) push(30'(32'h100 + i), (i == 9) ? 1'b1 : 1'b0);
      check("ten_occ", 32'(a_occ), 32'd10);
      pop(); pop(); pop();
      check("ten_occ7",  32'(a_occ), 32'd7);
      check("ten_head3", 32'(a_pkt), 32'h103);
      // Write, commit and pop in the same cycle leave occupancy unchanged.
      wr_en = 1'b1; wr_data = 30'h10A; commit = 1'b1; ren = 1'b1;
      step();
      wr_en = 1'b0; commit = 1'b0; ren = 1'b0;
      check("wcp_occ",  32'(a_occ), 32'd7);
      check("wcp_head", 32'(a_pkt), 32'h104);
      pulse_tick();
      check("ten_late", 32'(a_late), 32'h1);
`ifdef GRID_INPUT_BUFFER_STATS_EN
      check("stat_pops",    a_pops,           32'd4);
      check("stat_commits", 32'(a_commits),   32'd2);
`endif
      wr_en = 1'b1; ren = 1'b1; commit = 1'b1; tick = 1'b1; rst = 1'b0;
      step();
      rst = 1'b1; wr_en = 1'b0; ren = 1'b0; commit = 1'b0; tick = 1'b0;
      check("rst3_occ",   32'(a_occ),      32'h0);
      check("rst3_empty", 32'(a_empty),    32'h1);
      check("rst3_ready", 32'(a_wr_ready), 32'h1);
      check("rst3_flags", 32'({a_ovf, a_udf, a_late}), 32'h0);
`ifdef GRID_INPUT_BUFFER_STATS_EN
      check("rst3_pops",    a_pops,         32'd0);
      check("rst3_commits", 32'(a_commits), 32'd0);
`endif

      // DEPTH=4: the full boundary and overflow.
      sel = 1'b1;
      push(30'h1, 1'b0); push(30'h2, 1'b0); push(30'h3, 1'b0);
      check("d4_ready3", 32'(b_wr_ready), 32'h1);
      push(30'h4, 1'b0);
      check("d4_ready4", 32'(b_wr_ready), 32'h0);
      check("d4_occ4",   32'(b_occ),      32'd4);
      check("d4_ovf0",   32'(b_ovf),      32'h0);
      push(30'h5, 1'b0);
      check("d4_ovf1",   32'(b_ovf),      32'h1);
      check("d4_occ5",   32'(b_occ),      32'd4);
      pulse_commit();
      check("d4_head1", 32'(b_pkt), 32'h1);
      // A write while full is dropped even when a pop lands in the same cycle.
      wr_en = 1'b1; wr_data = 30'h9; ren = 1'b1;
      step();
      wr_en = 1'b0; ren = 1'b0;
      check("d4_fpop_occ",   32'(b_occ),      32'd3);
      check("d4_fpop_ready", 32'(b_wr_ready), 32'h1);
      check("d4_head2",      32'(b_pkt),      32'h2);
      pop(); check("d4_head3", 32'(b_pkt), 32'h3);
      pop(); check("d4_head4", 32'(b_pkt), 32'h4);
      pop();
      check("d4_empty", 32'(b_empty), 32'h1);
      check("d4_occ0",  32'(b_occ),   32'h0);
      check("d4_udf",   32'(b_udf),   32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/grid_input_buffer.md
GRID_INPUT_BUFFER -- requirements
Module: grid_input_buffer

Interface
REQ-001 SHALL have parameter PACKET_WIDTH, default 30, meaning the routed packet width: dx 9 + dy 9 + axon 8 + tick 4.
REQ-002 SHALL have parameter DEPTH, default 512, meaning the FIFO entry count; it SHALL be a power of two, minimum 4.
REQ-003 SHALL have port clk, input, 1, the single clock; every register updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-low reset, sampled on the clk rising edge.
REQ-005 SHALL have port tick, input, 1: a one-cycle global tick pulse, shared with the core grid.
REQ-006 SHALL have port wr_en, input, 1: host write request.
REQ-007 SHALL have port wr_data, input, PACKET_WIDTH: host packet.
REQ-008 SHALL have port wr_ready, output, 1: high when the FIFO is not full.
REQ-009 SHALL have port commit, input, 1: makes every packet written so far visible to the grid.
REQ-010 SHALL have port ren, input, 1: pop request from the grid's west-edge router (core 0).
REQ-011 SHALL have port packet_out, input-side of grid, output, PACKET_WIDTH: head-of-queue packet.
REQ-012 SHALL have port empty, output, 1: no committed packet is available to the grid.
REQ-013 SHALL have port occupancy, output, $clog2(DEPTH)+1: stored entries, committed plus uncommitted.
REQ-014 SHALL have port overflow_error, output, 1: sticky flag.
REQ-015 SHALL have port underflow_error, output, 1: sticky flag.
REQ-016 SHALL have port batch_late_error, output, 1: sticky flag.

Function
REQ-017 SHALL keep wr_ptr, commit_ptr and rd_ptr, each $clog2(DEPTH)+1 bits, wrapping modulo 2*DEPTH; the MSB distinguishes full from empty.
REQ-018 SHALL accept a write when wr_en=1 and wr_ready=1, storing wr_data at wr_ptr and incrementing wr_ptr.
REQ-019 SHALL drop a write when wr_en=1 and wr_ready=0, leaving storage unchanged and setting overflow_error.
REQ-020 SHALL define full as the case where wr_ptr and rd_ptr differ only in their MSB; wr_ready = !full.
REQ-021 SHALL, on commit=1, load commit_ptr with the post-write value of wr_ptr, so a write accepted in the same cycle is included in the commit.
REQ-022 SHALL drive empty = (rd_ptr == commit_ptr); uncommitted packets never clear empty.
REQ-023 SHALL present packet_out first-word-fall-through: mem[rd_ptr] is valid whenever empty=0, with no read latency.
REQ-024 SHALL, on ren=1 with empty=0, increment rd_ptr; the next entry appears on packet_out the following cycle.
REQ-025 SHALL, on ren=1 with empty=1, leave pointers unchanged and set underflow_error.
REQ-026 SHALL allow a write, a commit and a pop in the same cycle, each taking effect independently; occupancy changes by +1, -1 or 0 accordingly.
REQ-027 SHALL, on tick=1 with empty=0 (the previous batch is not drained), set batch_late_error; the FIFO contents are unaffected.
REQ-028 SHALL compute occupancy as wr_ptr - rd_ptr modulo 2*DEPTH; the value equals DEPTH when full.
REQ-029 SHALL never let the effective count exceed DEPTH; when a pop and a write coincide while full, the pop frees the slot in the next cycle, not the current one.

Reset
REQ-030 SHALL, while rst=0 at the clk edge, clear all pointers and all three error flags, regardless of any in-flight operation.
REQ-031 SHALL produce these values after reset: empty=1, wr_ready=1, occupancy=0 and packet_out don't-care; memory contents are not cleared.
REQ-032 SHALL ignore wr_en, commit, ren and tick in any cycle where rst=0.

Configuration
REQ-033 SHALL, with macro GRID_INPUT_BUFFER_STATS_EN defined, add a 32-bit output pop_count (accepted pops) and a 16-bit output commit_count (commit pulses); both are cleared by reset and wrap on overflow.
REQ-034 SHALL, without GRID_INPUT_BUFFER_STATS_EN, omit both counters and their ports entirely; all other behaviour is identical.

Verification
REQ-035 SHALL cover: write 3 packets (0x1, 0x2, 0x3) with no commit -> empty stays 1 and occupancy=3; commit -> empty=0 next cycle and packet_out=0x1.
REQ-036 SHALL cover: DEPTH=4, write 5 packets -> 4 stored, wr_ready=0 after the 4th, overflow_error=1; pop all 4 after commit in order 1..4, then empty=1.
REQ-037 SHALL cover: write and commit in the same cycle with the FIFO empty -> that packet is visible the next cycle (empty=0, packet_out equals the data).
REQ-038 SHALL cover: ren while empty -> underflow_error=1 and rd_ptr unchanged; a subsequent write+commit pops correctly.
REQ-039 SHALL cover: commit 2 packets, pop 1, assert tick -> batch_late_error=1; pop 1 more, then tick -> no new effect and the flag stays sticky.
REQ-040 SHALL cover: 10 packets committed, 3 popped, rst=0 for one cycle -> occupancy=0, empty=1 and all flags=0; with the stats macro defined, pop_count=0 after reset.
